// File: rtl/ppu_timing_pkg.sv
// ppu_timing_pkg: shared timing constants and types for the PPU H/V counter.
//   CNT_W / cnt_t : width and type of the horizontal and vertical counts.
//   NTSC_* / PAL_*: dots per line, lines per frame, vertical-blank first/last line.
//   in_range      : inclusive range test on a count value.
package ppu_timing_pkg;

  localparam int unsigned CNT_W = 9;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned NTSC_H_TOTAL  = 341;
  localparam int unsigned NTSC_V_TOTAL  = 262;
  localparam int unsigned NTSC_VB_START = 241;
  localparam int unsigned NTSC_VB_END   = 260;

  localparam int unsigned PAL_H_TOTAL   = 341;
  localparam int unsigned PAL_V_TOTAL   = 312;
  localparam int unsigned PAL_VB_START  = 241;
  localparam int unsigned PAL_VB_END    = 310;

  function automatic logic in_range(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/hv_counter_if.sv
// hv_counter_if: control inputs and timing outputs of the H/V counter.
//   CE, CLR, RENDER           : count enable, synchronous clear, rendering enabled.
//   H_out, V_out              : horizontal / vertical counts.
//   VB, BLNK, ODD, EOL, EOF   : vblank, blanking, frame parity, line/frame wrap pulses.
// Modports: master drives the controls, slave is the counter itself.
interface hv_counter_if;
  import ppu_timing_pkg::*;

  logic CE;
  logic CLR;
  logic RENDER;
  cnt_t H_out;
  cnt_t V_out;
  logic VB;
  logic BLNK;
  logic ODD;
  logic EOL;
  logic EOF;

  modport master (
    output CE, CLR, RENDER,
    input  H_out, V_out, VB, BLNK, ODD, EOL, EOF
  );

  modport slave (
    input  CE, CLR, RENDER,
    output H_out, V_out, VB, BLNK, ODD, EOL, EOF
  );

endinterface

// File: rtl/hv_wrap_cnt.sv
// hv_wrap_cnt: 9-bit wrapping counter.
//   clk, rst : clock, synchronous active-high reset.
//   en       : advance on this edge.
//   clr      : synchronous clear to 0 (over en).
//   term     : last value before wrapping to 0.
//   cnt      : registered count.
//   wrap     : combinational strobe, high when this edge wraps the count.
module hv_wrap_cnt
  import ppu_timing_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  cnt_t term,
  output cnt_t cnt,
  output logic wrap
);

  cnt_t nxt;

  // >= rather than == so a terminal lowered below the current count
  // still wraps instead of running past the total.
  assign wrap = en && (cnt >= term);

  always_comb begin
    nxt = cnt;
    if (clr)       nxt = '0;
    else if (wrap) nxt = '0;
    else if (en)   nxt = cnt + cnt_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= nxt;
  end

endmodule

// File: rtl/hv_counter.sv
// hv_counter: PPU horizontal/vertical dot and line counter.
//   PCLK : pixel clock, all state on the rising edge.
//   RES  : synchronous active-high reset.
//   bus  : hv_counter_if.slave (CE, CLR, RENDER in; H_out, V_out, VB, BLNK,
//          ODD, EOL, EOF out, all registered).
// Parameters: H_TOTAL, V_TOTAL, VB_START, VB_END (NTSC defaults).
// Build option: define ODD_FRAME_SKIP_EN to drop the last dot of every odd
// rendered frame.
module hv_counter
  import ppu_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL  = NTSC_H_TOTAL,
  parameter int unsigned V_TOTAL  = NTSC_V_TOTAL,
  parameter int unsigned VB_START = NTSC_VB_START,
  parameter int unsigned VB_END   = NTSC_VB_END
)
(
  input  logic         PCLK,
  input  logic         RES,
  hv_counter_if.slave  bus
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t VB_LO  = cnt_t'(VB_START);
  localparam cnt_t VB_HI  = cnt_t'(VB_END);

  cnt_t h_cnt;
  cnt_t v_cnt;
  cnt_t h_term;
  cnt_t v_nxt;
  logic h_wrap;
  logic v_wrap;
  logic vb_nxt;
  logic odd;
  logic vb;
  logic blnk;
  logic eol;
  logic eof;

  // The odd-frame skip is a shortened last line: lowering the H terminal
  // makes the line, and therefore the frame, wrap one dot early.
  always_comb begin
    h_term = H_LAST;
`ifdef ODD_FRAME_SKIP_EN
    if (odd && bus.RENDER && (v_cnt == V_LAST))
      h_term = cnt_t'(H_TOTAL - 2);
`endif
  end

  hv_wrap_cnt u_h (
    .clk  (PCLK),
    .rst  (RES),
    .en   (bus.CE),
    .clr  (bus.CLR),
    .term (h_term),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  hv_wrap_cnt u_v (
    .clk  (PCLK),
    .rst  (RES),
    .en   (h_wrap),
    .clr  (bus.CLR),
    .term (V_LAST),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  // Next V value, so VB changes on the same edge as V_out.
  always_comb begin
    v_nxt = v_cnt;
    if (bus.CLR)     v_nxt = '0;
    else if (v_wrap) v_nxt = '0;
    else if (h_wrap) v_nxt = v_cnt + cnt_t'(1);
  end

  assign vb_nxt = in_range(v_nxt, VB_LO, VB_HI);

  always_ff @(posedge PCLK) begin
    if (RES) begin
      odd  <= 1'b0;
      vb   <= 1'b0;
      blnk <= 1'b1;
      eol  <= 1'b0;
      eof  <= 1'b0;
    end else if (bus.CLR) begin
      vb   <= 1'b0;
      blnk <= ~bus.RENDER;
      eol  <= 1'b0;
      eof  <= 1'b0;
    end else begin
      eol  <= h_wrap;
      eof  <= v_wrap;
      if (v_wrap) odd <= ~odd;
      vb   <= vb_nxt;
      blnk <= ~bus.RENDER | vb_nxt;
    end
  end

  assign bus.H_out = h_cnt;
  assign bus.V_out = v_cnt;
  assign bus.VB    = vb;
  assign bus.BLNK  = blnk;
  assign bus.ODD   = odd;
  assign bus.EOL   = eol;
  assign bus.EOF   = eof;

endmodule

// File: tb/tb_hv_counter.sv
// tb_hv_counter: bench for hv_counter. One NTSC-sized instance covers the
// first line, a full frame and CE gating; a tiny instance (4 dots x 3 lines,
// vblank on line 1) covers clear/reset corners and the optional odd-frame skip.
module tb_hv_counter;
  import ppu_timing_pkg::*;

  localparam int unsigned SH   = 4;
  localparam int unsigned SV   = 3;
  localparam int unsigned SVBS = 1;
  localparam int unsigned SVBE = 1;
`ifdef ODD_FRAME_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed { logic res; logic clr; logic ce; logic render; } in_t;
  typedef struct packed {
    cnt_t h; cnt_t v; logic vb; logic blnk; logic odd; logic eol; logic eof;
  } obs_t;
  typedef struct packed { in_t in; obs_t exp; } vec_t;

  localparam in_t  IDLE  = 4'b0000;
  localparam in_t  RUN   = 4'b0010;
  localparam in_t  RUN_R = 4'b0011;
  localparam obs_t RST_OBS = {9'd0, 9'd0, 5'b01000};

  logic PCLK = 1'b0;
  logic n_res;
  logic s_res;
  always #5 PCLK = ~PCLK;

  hv_counter_if nbus();
  hv_counter_if sbus();

  hv_counter #(
    .H_TOTAL(NTSC_H_TOTAL), .V_TOTAL(NTSC_V_TOTAL),
    .VB_START(NTSC_VB_START), .VB_END(NTSC_VB_END)
  ) u_ntsc (.PCLK(PCLK), .RES(n_res), .bus(nbus.slave));

  hv_counter #(
    .H_TOTAL(SH), .V_TOTAL(SV), .VB_START(SVBS), .VB_END(SVBE)
  ) u_small (.PCLK(PCLK), .RES(s_res), .bus(sbus.slave));

  int   total = 0;
  int   bad   = 0;
  obs_t n_mdl = '0;
  obs_t s_mdl = '0;
  obs_t n_q[$];
  obs_t s_q[$];
  vec_t tab[20];

  function automatic obs_t ob(int unsigned h, int unsigned v, logic [4:0] fl);
    obs_t o;
    o.h = cnt_t'(h); o.v = cnt_t'(v);
    {o.vb, o.blnk, o.odd, o.eol, o.eof} = fl;
    return o;
  endfunction

  // Behavioural reference: one edge of the counter.
  function automatic obs_t model(obs_t s, in_t i, int unsigned ht, int unsigned vt,
                                 int unsigned vbs, int unsigned vbe);
    obs_t n;
    logic skip;
    n = s;
    if (i.res) return RST_OBS;
    n.eol = 1'b0; n.eof = 1'b0;
    if (i.clr) begin
      n.h = '0; n.v = '0; n.vb = 1'b0; n.blnk = !i.render;
      return n;
    end
    if (i.ce) begin
      skip = SKIP && s.odd && i.render && (s.v == cnt_t'(vt - 1)) && (s.h == cnt_t'(ht - 2));
      if (s.h != cnt_t'(ht - 1) && !skip) n.h = s.h + cnt_t'(1);
      else begin
        n.h = '0; n.eol = 1'b1;
        if (s.v != cnt_t'(vt - 1)) n.v = s.v + cnt_t'(1);
        else begin n.v = '0; n.eof = 1'b1; n.odd = !s.odd; end
      end
    end
    n.vb   = (n.v >= cnt_t'(vbs)) && (n.v <= cnt_t'(vbe));
    n.blnk = !i.render || n.vb;
    return n;
  endfunction

  function automatic obs_t obs_n();
    return {nbus.H_out, nbus.V_out, nbus.VB, nbus.BLNK, nbus.ODD, nbus.EOL, nbus.EOF};
  endfunction

  function automatic obs_t obs_s();
    return {sbus.H_out, sbus.V_out, sbus.VB, sbus.BLNK, sbus.ODD, sbus.EOL, sbus.EOF};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got h=%0d v=%0d vb=%b blnk=%b odd=%b eol=%b eof=%b expected h=%0d v=%0d vb=%b blnk=%b odd=%b eol=%b eof=%b",
               name, act.h, act.v, act.vb, act.blnk, act.odd, act.eol, act.eof,
               exp.h, exp.v, exp.vb, exp.blnk, exp.odd, exp.eol, exp.eof);
    end
  endtask

  // Drive both instances for one edge; expected values are queued at drive
  // time and popped once the edge has produced the DUT outputs.
  task automatic step(input in_t ni, input in_t si, input bit use_tab, input obs_t tab_exp);
    n_res = ni.res; nbus.CLR = ni.clr; nbus.CE = ni.ce; nbus.RENDER = ni.render;
    s_res = si.res; sbus.CLR = si.clr; sbus.CE = si.ce; sbus.RENDER = si.render;
    n_mdl = model(n_mdl, ni, NTSC_H_TOTAL, NTSC_V_TOTAL, NTSC_VB_START, NTSC_VB_END);
    s_mdl = model(s_mdl, si, SH, SV, SVBS, SVBE);
    n_q.push_back(n_mdl);
    s_q.push_back(use_tab ? tab_exp : s_mdl);
    @(posedge PCLK);
    #1;
    check_obs("ntsc", obs_n(), n_q.pop_front());
    check_obs(use_tab ? "table" : "small", obs_s(), s_q.pop_front());
  endtask

`ifdef ODD_FRAME_SKIP_EN
  task automatic small_frame(input in_t si, output int len);
    len = 0;
    do begin
      step(IDLE, si, 1'b0, '0);
      len++;
    end while (!sbus.EOF && len < 100);
  endtask
`endif

  initial begin
    int frame_cyc;
    int vb_cyc;
    int vb_first;
    int vb_last;
    int eol_cnt;
    bit reached;
`ifdef ODD_FRAME_SKIP_EN
    int flen;
`endif

    tab[0]  = '{in_t'(4'b1000), ob(0, 0, 5'b01000)};
    tab[1]  = '{in_t'(4'b0011), ob(1, 0, 5'b00000)};
    tab[2]  = '{in_t'(4'b0011), ob(2, 0, 5'b00000)};
    tab[3]  = '{in_t'(4'b0001), ob(2, 0, 5'b00000)};
    tab[4]  = '{in_t'(4'b0011), ob(3, 0, 5'b00000)};
    tab[5]  = '{in_t'(4'b0011), ob(0, 1, 5'b11010)};
    tab[6]  = '{in_t'(4'b0001), ob(0, 1, 5'b11000)};
    tab[7]  = '{in_t'(4'b0010), ob(1, 1, 5'b11000)};
    tab[8]  = '{in_t'(4'b0010), ob(2, 1, 5'b11000)};
    tab[9]  = '{in_t'(4'b0010), ob(3, 1, 5'b11000)};
    tab[10] = '{in_t'(4'b0010), ob(0, 2, 5'b01010)};
    tab[11] = '{in_t'(4'b0011), ob(1, 2, 5'b00000)};
    tab[12] = '{in_t'(4'b0011), ob(2, 2, 5'b00000)};
    tab[13] = '{in_t'(4'b0011), ob(3, 2, 5'b00000)};
    tab[14] = '{in_t'(4'b0011), ob(0, 0, 5'b00111)};
    tab[15] = '{in_t'(4'b0111), ob(0, 0, 5'b00100)};
    tab[16] = '{in_t'(4'b0010), ob(1, 0, 5'b01100)};
    tab[17] = '{in_t'(4'b0100), ob(0, 0, 5'b01100)};
    tab[18] = '{in_t'(4'b1111), ob(0, 0, 5'b01000)};
    tab[19] = '{in_t'(4'b0011), ob(1, 0, 5'b00000)};

    // Reset state
    step(in_t'(4'b1000), in_t'(4'b1000), 1'b0, '0);
    check_obs("reset_ntsc", obs_n(), RST_OBS);
    check_obs("reset_small", obs_s(), RST_OBS);

    // First NTSC line
    for (int i = 0; i < 340; i++) step(RUN, IDLE, 1'b0, '0);
    check("line_h340", nbus.H_out, 340);
    check("line_v0", nbus.V_out, 0);
    step(RUN, IDLE, 1'b0, '0);
    check("wrap_h0", nbus.H_out, 0);
    check("wrap_v1", nbus.V_out, 1);
    check("wrap_eol", nbus.EOL, 1);
    step(RUN, IDLE, 1'b0, '0);
    check("eol_one_cycle", nbus.EOL, 0);

    // Rest of the NTSC frame, RENDER=0
    frame_cyc = 342; vb_cyc = 0; vb_first = -1; vb_last = -1;
    while (!nbus.EOF && frame_cyc < 90000) begin
      step(RUN, IDLE, 1'b0, '0);
      frame_cyc++;
      if (nbus.VB) begin
        vb_cyc++;
        if (vb_first < 0) vb_first = int'(nbus.V_out);
        vb_last = int'(nbus.V_out);
      end
    end
    check("frame_len", frame_cyc, 89342);
    check("frame_odd", nbus.ODD, 1);
    check("frame_v0", nbus.V_out, 0);
    check("vb_cycles", vb_cyc, 20 * 341);
    check("vb_first_line", vb_first, 241);
    check("vb_last_line", vb_last, 260);

    // CE alternating: one advance per two edges, single-cycle EOL
    eol_cnt = 0;
    for (int i = 0; i < 682; i++) begin
      step((i % 2 == 0) ? RUN : IDLE, IDLE, 1'b0, '0);
      if (nbus.EOL) eol_cnt++;
    end
    check("toggle_h", nbus.H_out, 0);
    check("toggle_v", nbus.V_out, 1);
    check("toggle_eol_cnt", eol_cnt, 1);

    // Hand-computed vectors on the small instance
    for (int i = 0; i < 20; i++) step(IDLE, tab[i].in, 1'b1, tab[i].exp);

    // CLR on the last dot of the last line with ODD=1
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      step(IDLE, RUN, 1'b0, '0);
      reached = (sbus.H_out == cnt_t'(SH - 1)) && (sbus.V_out == cnt_t'(SV - 1)) && sbus.ODD;
    end
    check("clr_reach", reached, 1);
    step(IDLE, in_t'(4'b0110), 1'b0, '0);
    check_obs("clr_wrap", obs_s(), ob(0, 0, 5'b01100));

    // RES together with CLR mid-frame, inside vblank, ODD=1
    for (int i = 0; i < 6; i++) step(IDLE, RUN_R, 1'b0, '0);
    check_obs("pre_res", obs_s(), ob(2, 1, 5'b11100));
    step(IDLE, in_t'(4'b1111), 1'b0, '0);
    check_obs("res_clr", obs_s(), RST_OBS);

`ifdef ODD_FRAME_SKIP_EN
    step(IDLE, in_t'(4'b1000), 1'b0, '0);
    small_frame(RUN_R, flen); check("skip_f0_render", flen, SH * SV);
    small_frame(RUN_R, flen); check("skip_f1_render", flen, SH * SV - 1);
    small_frame(RUN,   flen); check("skip_f2_norender", flen, SH * SV);
    small_frame(RUN,   flen); check("skip_f3_norender", flen, SH * SV);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hv_counter.md
# hv_counter

Generates the 9-bit horizontal (dot) and vertical (line) counts that drive the PPU H/V timing decoder, plus the vertical-blank, blanking and frame-parity signals the decoder and video back-end consume. Sits upstream of the H/V decoding logic in the PPU timing path and runs on the pixel clock. Counts wrap at programmable line and frame totals. An optional odd-frame dot skip shortens every second rendered frame by one dot.

## Interface
- `H_TOTAL`, 341: dots per line; H counts 0..H_TOTAL-1.
- `V_TOTAL`, 262: lines per frame; V counts 0..V_TOTAL-1 (PAL build: 312).
- `VB_START`, 241: first vertical-blank line.
- `VB_END`, 260: last vertical-blank line, inclusive.

- `PCLK`  in  1  pixel clock; all state updates on the rising edge.
- `RES`  in  1  reset; synchronous and active-high.
- `CE`  in  1  count enable; counters advance only on edges where CE=1.
- `CLR`  in  1  synchronous clear of H/V to 0/0; frame parity unchanged.
- `RENDER`  in  1  rendering enabled (BG or sprites on).
- `H_out`  out  9  horizontal count.
- `V_out`  out  9  vertical count.
- `VB`  out  1  vertical blank active.
- `BLNK`  out  1  blanking: ~RENDER | VB.
- `ODD`  out  1  frame parity; toggles at each frame wrap.
- `EOL`  out  1  one-cycle pulse: line wrapped on previous edge.
- `EOF`  out  1  one-cycle pulse: frame wrapped on previous edge.

## Operation
- All outputs are registers. Reset values: H_out=0, V_out=0, VB=0, BLNK=1, ODD=0, EOL=0, EOF=0.
- Priority per edge: RES > CLR > CE counting.
- On CE=1: if H_out != H_TOTAL-1, H_out+1. Otherwise H_out=0, EOL=1, and V advances: if V_out != V_TOTAL-1, V_out+1; otherwise V_out=0, EOF=1, ODD toggles.
- On CE=0: H_out, V_out, ODD hold. EOL and EOF clear to 0, so pulses never stretch.
- CLR: H_out=0, V_out=0, EOL=0, EOF=0, VB=0, BLNK=~RENDER. No wrap pulses are produced.
- VB next-state is computed from the next V value. It is 1 iff VB_START <= V_next <= VB_END, so VB changes on the same edge as V_out.
- BLNK next-state = ~RENDER | VB_next, registered every edge regardless of CE.
- Arithmetic: 9-bit unsigned. Totals up to 512 are legal. Count values ≥ the total are unreachable after reset.

## Timing
- Latency: one PCLK from CE to visible count change. Wrap pulses appear the edge after the last dot, coincident with H_out=0.
- NTSC frame length with CE held high: 341×262 = 89342 cycles.
- Mid-frame RES: takes effect on the next edge. There is no partial state, and ODD returns to 0.
- When CLR and a wrap condition occur on the same edge, CLR wins: no EOL/EOF, and ODD does not toggle.

## Configuration
- `ODD_FRAME_SKIP_EN` defined: when ODD=1, RENDER=1, V_out=V_TOTAL-1 and H_out=H_TOTAL-2 with CE=1, the next edge behaves as the frame wrap. That edge sets H_out=0, V_out=0, EOL=1, EOF=1 and toggles ODD. The skipped frame lasts 89341 cycles. RENDER is sampled on that edge only.
- Macro undefined: no skip; every frame is H_TOTAL×V_TOTAL cycles.
- PAL builds leave the macro undefined.

## Structure
- Package `ppu_timing_pkg`: NTSC and PAL constants (341/262/241/260 and 341/312/241/310), plus the 9-bit count width.
- Sub-module `hv_wrap_cnt`: 9-bit counter with enable, synchronous clear, terminal value input and wrap strobe. It is instantiated twice, for H and for V, with the H wrap strobe feeding the V enable.
- Frame parity, skip logic and VB/BLNK registers live in the top.

## Test plan
- Reset then CE=1 for 341 cycles: H_out runs 0..340, then returns to 0 with EOL=1 for exactly one cycle, and V_out=1.
- Run a full frame, RENDER=0: EOF pulses after 89342 cycles, ODD goes 0→1, and VB is 1 exactly for V_out 241..260.
- Macro defined, RENDER=1: frame 0 takes 89342 cycles and frame 1 takes 89341. With RENDER=0, both take 89342.
- CE toggled 1/0 alternately: the count advances once per two cycles, and EOL stays high for only one cycle at a wrap.
- CLR asserted at H=340, V=261 with CE=1: outputs go to 0/0, EOF=0, and ODD is unchanged.
- RES asserted at V=250, H=100 together with CLR: all outputs take reset values on the next edge (VB=0, BLNK=1, ODD=0).
